// File: rtl/dn_mem_arbiter.sv
// dn_mem_arbiter: shares one single-port program/graphics memory between
// HPS ROM-download writes and game-CPU reads. It also captures DIP bytes
// from the DIP download index and holds the game core in reset during and
// after a download.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | port free; a buffered write wins over a pending CPU read
// WR    | single-cycle memory write from the download buffer
// RD    | CPU read; CE on the first cycle, then wait out MEM_LAT cycles
// DONE  | register memory data, pulse ack on the following cycle
module dn_mem_arbiter #(
  parameter int AW          = 19,
  parameter int MEM_LAT     = 1,
  parameter int HOLD_CYCLES = 16,
  parameter int DIP_INDEX   = 254
) (
  input  logic          I_CLK_24576M,
  input  logic          I_RESETn,
  input  logic          I_DN_ACTIVE,
  input  logic          I_DN_WR,
  input  logic [7:0]    I_DN_INDEX,
  input  logic [AW-1:0] I_DN_ADDR,
  input  logic [7:0]    I_DN_DATA,
  input  logic          I_CPU_REQ,
  input  logic [AW-1:0] I_CPU_ADDR,
  output logic [7:0]    O_CPU_DATA,
  output logic          O_CPU_ACK,
  output logic [AW-1:0] O_MEM_ADDR,
  output logic [7:0]    O_MEM_DIN,
  output logic          O_MEM_WE,
  output logic          O_MEM_CE,
  input  logic [7:0]    I_MEM_Q,
  output logic [63:0]   O_DIP_SW,
  output logic          O_CORE_RESETn,
  output logic          O_DN_OVF
);

  typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_DONE} state_t;

  localparam logic [1:0] LAT_LOAD  = 2'(MEM_LAT - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

  state_t        state;
  logic          buf_full;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic [1:0]    lat_cnt;
  logic [7:0]    hold_cnt;

  logic buf_release;
  logic dn_buf_wr;
  logic dip_wr;

  // The buffer empties at the end of the WR cycle, so a strobe landing in
  // that same cycle can refill it instead of being dropped.
  assign buf_release = (state == ST_WR);
  assign dn_buf_wr   = I_DN_WR && (I_DN_INDEX == 8'd0);
  assign dip_wr      = I_DN_WR && (I_DN_INDEX == 8'(DIP_INDEX)) &&
                       (I_DN_ADDR[AW-1:3] == '0);

  // One-entry download write buffer plus sticky overflow flag.
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      buf_full <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      O_DN_OVF <= 1'b0;
    end else begin
      if (dn_buf_wr && (!buf_full || buf_release)) begin
        buf_full <= 1'b1;
        buf_addr <= I_DN_ADDR;
        buf_data <= I_DN_DATA;
      end else if (buf_release) begin
        buf_full <= 1'b0;
      end
      if (dn_buf_wr && buf_full && !buf_release)
        O_DN_OVF <= 1'b1;
    end
  end

  // DIP bytes bypass the memory path entirely.
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn)
      O_DIP_SW <= '0;
    else if (dip_wr)
      O_DIP_SW[{I_DN_ADDR[2:0], 3'b000} +: 8] <= I_DN_DATA;
  end

  // Memory port arbitration FSM with registered port and CPU outputs.
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state      <= ST_IDLE;
      O_MEM_ADDR <= '0;
      O_MEM_DIN  <= '0;
      O_MEM_WE   <= 1'b0;
      O_MEM_CE   <= 1'b0;
      O_CPU_DATA <= '0;
      O_CPU_ACK  <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      O_CPU_ACK <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (buf_full) begin
            state      <= ST_WR;
            O_MEM_WE   <= 1'b1;
            O_MEM_CE   <= 1'b1;
            O_MEM_ADDR <= buf_addr;
            O_MEM_DIN  <= buf_data;
          end else if (I_CPU_REQ && !I_DN_ACTIVE) begin
            state      <= ST_RD;
            O_MEM_CE   <= 1'b1;
            O_MEM_ADDR <= I_CPU_ADDR;
            lat_cnt    <= LAT_LOAD;
          end
        end
        ST_WR: begin
          O_MEM_WE <= 1'b0;
          O_MEM_CE <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_RD: begin
          O_MEM_CE <= 1'b0;
          if (lat_cnt == 2'd0)
            state <= ST_DONE;
          else
            lat_cnt <= lat_cnt - 2'd1;
        end
        ST_DONE: begin
          O_CPU_DATA <= I_MEM_Q;
          O_CPU_ACK  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Core reset hold: reload while downloading, count down after, release
  // one cycle after the counter hits zero.
  always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      hold_cnt      <= HOLD_LOAD;
      O_CORE_RESETn <= 1'b0;
    end else if (I_DN_ACTIVE) begin
      hold_cnt      <= HOLD_LOAD;
      O_CORE_RESETn <= 1'b0;
    end else if (hold_cnt != 8'd0) begin
      hold_cnt <= hold_cnt - 8'd1;
    end else begin
      O_CORE_RESETn <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dn_mem_arbiter.sv
// Testbench for dn_mem_arbiter: directed download/CPU stimulus, a
// reservation-based model of the shared memory port, and a per-cycle
// compare against that model plus literal spot checks.
module tb_dn_mem_arbiter;

  localparam int AW   = 19;
  localparam int LAT  = 1;
  localparam int HOLD = 16;
  localparam int DIPI = 254;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          dn_active, dn_wr, cpu_req;
  logic [7:0]    dn_index, dn_data;
  logic [AW-1:0] dn_addr, cpu_addr;
  logic [7:0]    cpu_data, mem_din, mem_q;
  logic          cpu_ack, mem_we, mem_ce, core_resetn, dn_ovf;
  logic [AW-1:0] mem_addr;
  logic [63:0]   dip_sw;

  int n_cmp = 0;
  int n_fail = 0;

  dn_mem_arbiter #(.AW(AW), .MEM_LAT(LAT), .HOLD_CYCLES(HOLD), .DIP_INDEX(DIPI)) dut (
    .I_CLK_24576M (clk),
    .I_RESETn     (rst_n),
    .I_DN_ACTIVE  (dn_active),
    .I_DN_WR      (dn_wr),
    .I_DN_INDEX   (dn_index),
    .I_DN_ADDR    (dn_addr),
    .I_DN_DATA    (dn_data),
    .I_CPU_REQ    (cpu_req),
    .I_CPU_ADDR   (cpu_addr),
    .O_CPU_DATA   (cpu_data),
    .O_CPU_ACK    (cpu_ack),
    .O_MEM_ADDR   (mem_addr),
    .O_MEM_DIN    (mem_din),
    .O_MEM_WE     (mem_we),
    .O_MEM_CE     (mem_ce),
    .I_MEM_Q      (mem_q),
    .O_DIP_SW     (dip_sw),
    .O_CORE_RESETn(core_resetn),
    .O_DN_OVF     (dn_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dflt(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // ---------------- memory environment (driven by the DUT port) ----------
  logic [7:0] env_mem [int];
  logic       pv [LAT];
  logic [7:0] pd [LAT];

  function automatic logic [7:0] env_rd(input logic [AW-1:0] a);
    if (env_mem.exists(int'(a))) return env_mem[int'(a)];
    return dflt(a);
  endfunction

  // Synchronous memory: data valid LAT cycles after the CE cycle, then held.
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = mem_ce && !mem_we;
    pd[0] = env_rd(mem_addr);
    if (mem_ce && mem_we) env_mem[int'(mem_addr)] = mem_din;
    if (pv[LAT-1]) mem_q <= pd[LAT-1];
  end

  // ---------------- behavioural model ------------------------------------
  // The port is treated as a resource: each granted transaction reserves a
  // window of future cycles whose outputs are written into a small schedule.
  logic [7:0]    mdl_mem [int];
  bit            s_ce [16], s_we [16], s_ack [16];
  logic [AW-1:0] s_addr [16];
  logic [7:0]    s_din [16], s_data [16];
  int            cyc, idle_at, wr_cycle, act_free;
  bit            m_buf_valid;
  logic [AW-1:0] m_buf_addr;
  logic [7:0]    m_buf_data;
  logic [63:0]   m_dip;
  bit            m_ovf;
  bit            chk_en = 1'b0;
  logic          exp_we = 0, exp_ce = 0, exp_ack = 0, exp_rstn = 0, exp_ovf = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [7:0]    exp_din = '0, exp_data = '0;
  logic [63:0]   exp_dip = '0;

  function automatic logic [7:0] mdl_rd(input logic [AW-1:0] a);
    if (mdl_mem.exists(int'(a))) return mdl_mem[int'(a)];
    return dflt(a);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0; idle_at = 0; wr_cycle = -1; act_free = 0;
      m_buf_valid = 0; m_buf_addr = '0; m_buf_data = '0; m_dip = '0; m_ovf = 0;
      for (int i = 0; i < 16; i++) begin
        s_ce[i] = 0; s_we[i] = 0; s_ack[i] = 0; s_addr[i] = '0; s_din[i] = '0; s_data[i] = '0;
      end
      exp_we = 0; exp_ce = 0; exp_ack = 0; exp_rstn = 0; exp_ovf = 0;
      exp_addr = '0; exp_din = '0; exp_data = '0; exp_dip = '0;
      chk_en = 1'b1;
    end else begin
      automatic int  t = cyc;
      automatic bit  freeing = (t == wr_cycle);
      automatic int  k;
      if (t >= idle_at) begin
        if (m_buf_valid) begin
          k = (t + 1) % 16;
          s_ce[k] = 1; s_we[k] = 1; s_addr[k] = m_buf_addr; s_din[k] = m_buf_data;
          mdl_mem[int'(m_buf_addr)] = m_buf_data;
          wr_cycle = t + 1;
          idle_at = t + 2;
        end else if (cpu_req && !dn_active) begin
          k = (t + 1) % 16;
          s_ce[k] = 1; s_addr[k] = cpu_addr;
          k = (t + 2 + LAT) % 16;
          s_ack[k] = 1; s_data[k] = mdl_rd(cpu_addr);
          idle_at = t + 2 + LAT;
        end
      end
      if (freeing) m_buf_valid = 0;
      if (dn_wr && dn_index == 8'd0) begin
        if (m_buf_valid) m_ovf = 1;
        else begin
          m_buf_valid = 1; m_buf_addr = dn_addr; m_buf_data = dn_data;
        end
      end
      if (dn_wr && dn_index == 8'(DIPI) && dn_addr < 8)
        m_dip[int'(dn_addr) * 8 +: 8] = dn_data;
      if (dn_active) act_free = 0;
      else act_free++;
      k = (t + 1) % 16;
      exp_we = s_we[k]; exp_ce = s_ce[k]; exp_addr = s_addr[k]; exp_din = s_din[k];
      exp_ack = s_ack[k];
      if (s_ack[k]) exp_data = s_data[k];
      s_ce[k] = 0; s_we[k] = 0; s_ack[k] = 0;
      exp_rstn = (act_free > HOLD);
      exp_dip = m_dip;
      exp_ovf = m_ovf;
      cyc = t + 1;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("core_resetn", 64'(core_resetn), 64'(exp_rstn));
      check("mem_we", 64'(mem_we), 64'(exp_we));
      check("mem_ce", 64'(mem_ce), 64'(exp_ce));
      if (exp_ce) check("mem_addr", 64'(mem_addr), 64'(exp_addr));
      if (exp_we) check("mem_din", 64'(mem_din), 64'(exp_din));
      check("cpu_ack", 64'(cpu_ack), 64'(exp_ack));
      check("cpu_data", 64'(cpu_data), 64'(exp_data));
      check("dip_sw", dip_sw, exp_dip);
      check("dn_ovf", 64'(dn_ovf), 64'(exp_ovf));
    end
  end

  // ---------------- directed stimulus with literal spot checks -----------
  task automatic dn_strobe(input logic [7:0] idx, input logic [AW-1:0] a, input logic [7:0] d);
    dn_wr = 1; dn_index = idx; dn_addr = a; dn_data = d;
  endtask

  initial begin
    dn_active = 0; dn_wr = 0; dn_index = 0; dn_addr = '0; dn_data = 0;
    cpu_req = 0; cpu_addr = '0;
    env_mem[32'h0ABCD] = 8'h3C;
    mdl_mem[32'h0ABCD] = 8'h3C;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dip", dip_sw, 64'h0);
    check("rst_resetn", 64'(core_resetn), 64'h0);
    rst_n = 1;

    // Reset hold after reset release
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) check("hold_edge16", 64'(core_resetn), 64'h0);
      if (k == 17) check("hold_edge17", 64'(core_resetn), 64'h1);
    end

    // Single buffered write: WE two cycles after the strobe
    dn_strobe(8'd0, 19'h00123, 8'hA5);
    tick(); dn_wr = 0;
    check("wr_c1_we", 64'(mem_we), 64'h0);
    tick();
    check("wr_c2_we", 64'(mem_we), 64'h1);
    check("wr_c2_addr", 64'(mem_addr), 64'h00123);
    check("wr_c2_din", 64'(mem_din), 64'hA5);
    tick();
    check("wr_c3_we", 64'(mem_we), 64'h0);
    check("wr_ovf", 64'(dn_ovf), 64'h0);

    // Strobe during the WR cycle refills the freed buffer
    dn_strobe(8'd0, 19'h00300, 8'h11);
    tick(); dn_wr = 0;
    tick();
    check("wrb_first_we", 64'(mem_we), 64'h1);
    dn_strobe(8'd0, 19'h00301, 8'h22);
    tick(); dn_wr = 0;
    tick();
    check("wrb_second_we", 64'(mem_we), 64'h1);
    check("wrb_second_addr", 64'(mem_addr), 64'h00301);
    check("wrb_ovf", 64'(dn_ovf), 64'h0);
    tick();

    // DIP capture, then an out-of-range DIP address
    for (int i = 0; i < 8; i++) begin
      dn_strobe(8'(DIPI), AW'(i), 8'h10 + 8'(i));
      tick();
    end
    dn_strobe(8'(DIPI), 19'd8, 8'hEE);
    tick(); dn_wr = 0;
    tick();
    check("dip_value", dip_sw, 64'h1716151413121110);

    // CPU read, MEM_LAT=1: CE at cycle 1, ACK at cycle 3
    cpu_req = 1; cpu_addr = 19'h0ABCD;
    tick();
    check("rd_c1_ce", 64'(mem_ce), 64'h1);
    check("rd_c1_addr", 64'(mem_addr), 64'h0ABCD);
    tick();
    check("rd_c2_ack", 64'(cpu_ack), 64'h0);
    tick();
    check("rd_c3_ack", 64'(cpu_ack), 64'h1);
    check("rd_c3_data", 64'(cpu_data), 64'h3C);
    cpu_req = 0;
    tick();
    check("rd_c4_ack", 64'(cpu_ack), 64'h0);

    // Write arriving mid-read waits; second strobe overflows
    cpu_req = 1; cpu_addr = 19'h00050;
    tick();
    dn_strobe(8'd0, 19'h00200, 8'h77);
    tick();
    dn_strobe(8'd0, 19'h00201, 8'h88);
    tick(); dn_wr = 0;
    check("mix_ack", 64'(cpu_ack), 64'h1);
    check("mix_data", 64'(cpu_data), 64'h0A);
    check("mix_ovf", 64'(dn_ovf), 64'h1);
    cpu_req = 0;
    tick();
    check("mix_wr_we", 64'(mem_we), 64'h1);
    check("mix_wr_addr", 64'(mem_addr), 64'h00200);
    check("mix_wr_din", 64'(mem_din), 64'h77);
    repeat (3) tick();

    // Read back the buffered write
    cpu_req = 1; cpu_addr = 19'h00200;
    repeat (3) tick();
    check("rb_ack", 64'(cpu_ack), 64'h1);
    check("rb_data", 64'(cpu_data), 64'h77);
    cpu_req = 0;
    repeat (2) tick();

    // Download active, 5-cycle gap, active again with a pending read
    dn_active = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("act1_resetn", 64'(core_resetn), 64'h0);
    end
    dn_active = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("gap_resetn", 64'(core_resetn), 64'h0);
    end
    dn_active = 1; cpu_req = 1; cpu_addr = 19'h0ABCD;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("act2_resetn", 64'(core_resetn), 64'h0);
      check("act2_noack", 64'(cpu_ack), 64'h0);
    end
    dn_active = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 3) begin
        check("rel_ack", 64'(cpu_ack), 64'h1);
        check("rel_data", 64'(cpu_data), 64'h3C);
        cpu_req = 0;
      end
      if (k == 16) check("rel_hold16", 64'(core_resetn), 64'h0);
      if (k == 17) check("rel_hold17", 64'(core_resetn), 64'h1);
    end
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
